// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory request/completion bundle for the MEM stage
//
// Purpose: groups the req/done handshake between the memory-access stage and
// a multi-cycle data memory.
// Signals:
//   mem_req    stage -> mem  one-cycle request pulse
//   mem_we     stage -> mem  1=write, 0=read, valid with mem_req
//   mem_addr   stage -> mem  access address, valid with mem_req
//   mem_wdata  stage -> mem  store data, valid with mem_req
//   mem_rdata  mem -> stage  load data, valid with mem_done
//   mem_done   mem -> stage  one-cycle completion pulse
interface mem_wb_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage with MEM/WB pipeline register
//
// Purpose: performs at most one data-memory access per instruction over a
// req/done handshake, stalls upstream while the access is outstanding, and
// registers results into MEM/WB for the writeback mux.
// Optional feature macro: ALIGN_CHK_EN (misaligned memory ops become
// exceptions without touching memory).
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid .. Excp         EX/MEM register contents
//   flush                    squash the instruction currently in the stage
//   mem (master)             data-memory handshake
//   stall_o                  hold PC/IF-ID/ID-EX/EX-MEM this cycle
//   valid_o .. Excp_o        registered MEM/WB outputs
//   timeout_err              sticky access-timeout flag
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_two,
  input  logic [2:0]        RD,
  input  logic [1:0]        Dst_reg,
  input  logic              Reg_write,
  input  logic              Mem_read,
  input  logic              Mem_write,
  input  logic              JAL,
  input  logic              Mem_reg,
  input  logic              Mem_en,
  input  logic              Excp,
  input  logic              flush,
  mem_wb_stage_if.master    mem,
  output logic              stall_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [2:0]        RD_o,
  output logic [1:0]        Dst_reg_o,
  output logic              Reg_write_o,
  output logic              JAL_o,
  output logic              Mem_reg_o,
  output logic              Excp_o,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        rd;
    logic [1:0]        dst;
    logic              rw;
    logic              jal;
    logic              mreg;
    logic              excp;
  } wb_t;

  // Instruction fields held while the access is outstanding.
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [2:0]        rd;
    logic [1:0]        dst;
    logic              rw;
    logic              jal;
    logic              mreg;
    logic              is_read;
  } cap_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  wb_t               wb_q, wb_d;
  cap_t              cap_q, cap_d;
  logic              flushed_q, flushed_d;
  logic              terr_q, terr_d;
  logic              req_c, stall_c;

  logic mem_op, conflict, misalign, excp_any, needs_mem, pass_valid;

  assign mem_op   = in_valid & Mem_en & (Mem_read | Mem_write);
  assign conflict = Mem_read & Mem_write;
`ifdef ALIGN_CHK_EN
  assign misalign = data_out[0];
`else
  assign misalign = 1'b0;
`endif
  // Conflicting or misaligned memory ops degrade to pass-through exceptions.
  assign excp_any   = Excp | (mem_op & (conflict | misalign));
  assign needs_mem  = mem_op & ~conflict & ~misalign & ~Excp & ~flush;
  assign pass_valid = in_valid & ~flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_d      = wb_q;
    cap_d     = cap_q;
    flushed_d = flushed_q;
    terr_d    = terr_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (needs_mem) begin
          req_c         = 1'b1;
          stall_c       = 1'b1;
          cap_d.alu     = data_out;
          cap_d.rd      = RD;
          cap_d.dst     = Dst_reg;
          cap_d.rw      = Reg_write;
          cap_d.jal     = JAL;
          cap_d.mreg    = Mem_reg;
          cap_d.is_read = Mem_read;
          flushed_d     = 1'b0;
          cnt_d         = '0;
          state_d       = WAIT;
          wb_d          = '0;
        end else begin
          wb_d.valid = pass_valid;
          wb_d.alu   = data_out;
          wb_d.rdata = '0;
          wb_d.rd    = RD;
          wb_d.dst   = Dst_reg;
          wb_d.rw    = Reg_write & pass_valid & ~excp_any;
          wb_d.jal   = JAL;
          wb_d.mreg  = Mem_reg;
          wb_d.excp  = excp_any & pass_valid;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.mem_done || cnt_q == CNT_LAST) begin
          wb_d.alu   = cap_q.alu;
          wb_d.rd    = cap_q.rd;
          wb_d.dst   = cap_q.dst;
          wb_d.jal   = cap_q.jal;
          wb_d.mreg  = cap_q.mreg;
          state_d    = IDLE;
          cnt_d      = '0;
          // A flush arriving in the completion cycle still squashes the result.
          if (mem.mem_done) begin
            wb_d.valid = ~(flushed_q | flush);
            wb_d.rw    = cap_q.rw & ~(flushed_q | flush);
            wb_d.rdata = cap_q.is_read ? mem.mem_rdata : '0;
            wb_d.excp  = 1'b0;
          end else begin
            wb_d.valid = 1'b1;
            wb_d.rw    = 1'b0;
            wb_d.rdata = '0;
            wb_d.excp  = 1'b1;
            terr_d     = 1'b1;
          end
        end else begin
          stall_c = 1'b1;
          if (flush) flushed_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_q      <= '0;
      cap_q     <= '0;
      flushed_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      cap_q     <= cap_d;
      flushed_q <= flushed_d;
      terr_q    <= terr_d;
    end
  end

  // Gated by rst so the combinational request/stall drop as soon as reset
  // asserts, even while EX/MEM still presents a memory op.
  assign mem.mem_req   = req_c & rst;
  assign stall_o       = stall_c & rst;
  assign mem.mem_we    = Mem_write;
  assign mem.mem_addr  = data_out;
  assign mem.mem_wdata = data_two;

  assign valid_o     = wb_q.valid;
  assign alu_o       = wb_q.alu;
  assign rdata_o     = wb_q.rdata;
  assign RD_o        = wb_q.rd;
  assign Dst_reg_o   = wb_q.dst;
  assign Reg_write_o = wb_q.rw;
  assign JAL_o       = wb_q.jal;
  assign Mem_reg_o   = wb_q.mreg;
  assign Excp_o      = wb_q.excp;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  localparam int DW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, Reg_write, Mem_read, Mem_write, JAL, Mem_reg, Mem_en, Excp, flush;
  logic [DW-1:0] data_out, data_two;
  logic [2:0]    RD;
  logic [1:0]    Dst_reg;
  logic          stall_o, valid_o, Reg_write_o, JAL_o, Mem_reg_o, Excp_o, timeout_err;
  logic [DW-1:0] alu_o, rdata_o;
  logic [2:0]    RD_o;
  logic [1:0]    Dst_reg_o;

  mem_wb_stage_if #(.DATA_W(DW)) mif ();

  mem_wb_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_out(data_out), .data_two(data_two),
    .RD(RD), .Dst_reg(Dst_reg), .Reg_write(Reg_write), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .JAL(JAL), .Mem_reg(Mem_reg), .Mem_en(Mem_en), .Excp(Excp),
    .flush(flush), .mem(mif), .stall_o(stall_o), .valid_o(valid_o), .alu_o(alu_o),
    .rdata_o(rdata_o), .RD_o(RD_o), .Dst_reg_o(Dst_reg_o), .Reg_write_o(Reg_write_o),
    .JAL_o(JAL_o), .Mem_reg_o(Mem_reg_o), .Excp_o(Excp_o), .timeout_err(timeout_err)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic exp_terr = 1'b0;

  // Instruction to present next.
  logic          iv, rw, mr, mw, jal, mreg, men, exc, fl;
  logic [DW-1:0] a, d;
  logic [2:0]    rd;
  logic [1:0]    dst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic w, input logic r, input logic wr,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wd, input logic [2:0] r_d);
    iv = v; rw = w; mr = r; mw = wr; men = r | wr; a = addr; d = wd; rd = r_d;
    dst = 2'd1; jal = 1'b0; mreg = r; exc = 1'b0; fl = 1'b0;
  endtask

  // Presents one instruction, plays the memory with done 'lat' cycles after
  // the request, optionally flushes on WAIT cycle 'flush_at', then checks MEM/WB.
  task automatic run_instr(input string tag, input int lat, input int flush_at, input logic [DW-1:0] rdat);
    logic conflict, misal, access, excp_any, pv, fl_seen, done, tmo;
    logic ev, erw, eexc;
    logic [DW-1:0] erd;
    @(negedge clk);
    in_valid = iv; Reg_write = rw; Mem_read = mr; Mem_write = mw; JAL = jal; Mem_reg = mreg;
    Mem_en = men; Excp = exc; flush = fl; data_out = a; data_two = d; RD = rd; Dst_reg = dst;
    mif.mem_done = 1'b0;
    #1;
    conflict = men & mr & mw;
    misal = 1'b0;
`ifdef ALIGN_CHK_EN
    misal = men & (mr | mw) & a[0];
`endif
    access = iv & men & (mr | mw) & ~exc & ~fl & ~conflict & ~misal;
    chk({tag, ":req"}, mif.mem_req, access);
    chk({tag, ":stall0"}, stall_o, access);
    fl_seen = 1'b0; done = 1'b0; tmo = 1'b0;
    if (access) begin
      chk({tag, ":addr"}, mif.mem_addr, a);
      chk({tag, ":we"}, mif.mem_we, mw);
      if (mw) chk({tag, ":wdata"}, mif.mem_wdata, d);
      for (int k = 1; k <= TO + 2 && !done && !tmo; k++) begin
        @(negedge clk);
        flush = (k == flush_at);
        mif.mem_done = (k == lat);
        mif.mem_rdata = rdat;
        if (flush) fl_seen = 1'b1;
        #1;
        chk({tag, ":req_wait"}, mif.mem_req, 1'b0);
        chk({tag, ":bubble"}, valid_o, 1'b0);
        done = (k == lat);
        tmo  = !done && (k == TO);
        chk({tag, ":stall_wait"}, stall_o, !done && !tmo);
      end
      if (done) begin
        ev = ~fl_seen; erw = rw & ~fl_seen; eexc = 1'b0; erd = mr ? rdat : '0;
      end else begin
        ev = 1'b1; erw = 1'b0; eexc = 1'b1; erd = '0; exp_terr = 1'b1;
      end
    end else begin
      pv = iv & ~fl;
      excp_any = exc | (iv & men & (conflict | misal));
      ev = pv; eexc = excp_any & pv; erw = rw & pv & ~excp_any; erd = '0;
    end
    @(negedge clk);
    mif.mem_done = 1'b0; flush = 1'b0; in_valid = 1'b0; Mem_en = 1'b0;
    chk({tag, ":valid"}, valid_o, ev);
    chk({tag, ":rw"}, Reg_write_o, erw);
    chk({tag, ":excp"}, Excp_o, eexc);
    chk({tag, ":terr"}, timeout_err, exp_terr);
    if (ev && !tmo) begin
      chk({tag, ":alu"}, alu_o, a);
      chk({tag, ":rdata"}, rdata_o, erd);
      chk({tag, ":rd"}, RD_o, rd);
      chk({tag, ":dst"}, Dst_reg_o, dst);
      chk({tag, ":jal"}, JAL_o, jal);
      chk({tag, ":mreg"}, Mem_reg_o, mreg);
    end
  endtask

  initial begin
    int op, lat, fat;
    rst = 1'b0;
    in_valid = 0; Reg_write = 0; Mem_read = 0; Mem_write = 0; JAL = 0; Mem_reg = 0;
    Mem_en = 0; Excp = 0; flush = 0; data_out = '0; data_two = '0; RD = '0; Dst_reg = '0;
    mif.mem_done = 1'b0; mif.mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst:valid", valid_o, 1'b0);
    chk("rst:alu", alu_o, '0);
    chk("rst:stall", stall_o, 1'b0);
    chk("rst:req", mif.mem_req, 1'b0);
    chk("rst:terr", timeout_err, 1'b0);
    rst = 1'b1;

    set_instr(1, 1, 0, 0, 16'h1234, 16'h0, 3'd3);
    run_instr("alu", 0, 0, '0);
    set_instr(1, 1, 1, 0, 16'h0040, 16'h0, 3'd5);
    run_instr("load", 3, 0, 16'hBEEF);
    set_instr(1, 0, 0, 1, 16'h0010, 16'h00A5, 3'd0);
    run_instr("store", 2, 0, 16'h5555);
    set_instr(1, 1, 1, 0, 16'h0020, 16'h0, 3'd2);
    run_instr("flushwait", 3, 1, 16'h1111);
    set_instr(1, 1, 1, 1, 16'h0030, 16'h0, 3'd4);
    run_instr("conflict", 0, 0, '0);
    set_instr(1, 1, 1, 0, 16'h0050, 16'h0, 3'd6);
    exc = 1'b1;
    run_instr("excp_in", 0, 0, '0);
    set_instr(1, 1, 1, 0, 16'h0060, 16'h0, 3'd7);
    fl = 1'b1;
    run_instr("flushidle", 0, 0, '0);
    set_instr(1, 1, 1, 0, 16'h0070, 16'h0, 3'd1);
    run_instr("lat_max", TO, 0, 16'h7777);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      set_instr(($urandom % 8) != 0, $urandom % 2, op == 1 || op == 2 || op == 5,
                op == 3 || op == 4 || op == 5, 16'($urandom), 16'($urandom), 3'($urandom));
      jal = 1'($urandom); dst = 2'($urandom);
      exc = ($urandom % 8) == 0;
      fl  = ($urandom % 8) == 0;
      lat = $urandom_range(1, TO + 1);
      fat = (($urandom % 3) == 0) ? $urandom_range(1, lat) : 0;
      run_instr("rand", lat, fat, 16'($urandom));
    end

    set_instr(1, 1, 1, 0, 16'h0080, 16'h0, 3'd3);
    run_instr("timeout", 1000, 0, '0);
    @(negedge clk);
    mif.mem_done = 1'b1; mif.mem_rdata = 16'hDEAD;
    #1;
    chk("stray:req", mif.mem_req, 1'b0);
    chk("stray:stall", stall_o, 1'b0);
    @(negedge clk);
    mif.mem_done = 1'b0;
    chk("stray:terr", timeout_err, 1'b1);
    chk("stray:valid", valid_o, 1'b0);
    set_instr(1, 1, 1, 0, 16'h0090, 16'h0, 3'd2);
    run_instr("after_to", 2, 0, 16'h4242);

    @(negedge clk);
    in_valid = 1; Mem_en = 1; Mem_read = 1; Mem_write = 0; Excp = 0; flush = 0; data_out = 16'h00A0;
    #1;
    chk("rstw:req", mif.mem_req, 1'b1);
    @(negedge clk);
    #1;
    chk("rstw:stall_pre", stall_o, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstw:stall", stall_o, 1'b0);
    chk("rstw:req", mif.mem_req, 1'b0);
    chk("rstw:valid", valid_o, 1'b0);
    chk("rstw:terr", timeout_err, 1'b0);
    exp_terr = 1'b0;
    in_valid = 0; Mem_en = 0;
    @(negedge clk);
    rst = 1'b1;
    set_instr(1, 1, 0, 0, 16'h4321, 16'h0, 3'd6);
    run_instr("post_rst", 0, 0, '0);

`ifdef ALIGN_CHK_EN
    set_instr(1, 1, 1, 0, 16'h0041, 16'h0, 3'd3);
    run_instr("misalign", 2, 0, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs and performs at most one data-memory access per instruction over a req/done handshake with a multi-cycle data memory. It stalls the upstream stages while the access is outstanding. Results are registered into MEM/WB outputs for the writeback mux.

Parameters:
DATA_W, 16, datapath width (address, store data, load data)
TIMEOUT, 64, max WAIT cycles before the access is abandoned; >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM holds a live instruction
data_out  in  DATA_W  ALU result / memory address
data_two  in  DATA_W  store data
RD  in  3  destination register number
Dst_reg  in  2  dest-select control, passed through
Reg_write, Mem_read, Mem_write, JAL, Mem_reg, Mem_en, Excp  in  1 each  control from EX/MEM
flush  in  1  squash instruction currently in stage
mem_req  out  1  one-cycle request pulse
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr, mem_wdata  out  DATA_W  valid with mem_req
mem_rdata  in  DATA_W  valid when mem_done=1
mem_done  in  1  one-cycle completion pulse
stall_o  out  1  hold PC/IF-ID/ID-EX/EX-MEM this cycle
valid_o  out  1  MEM/WB holds live instruction
alu_o, rdata_o  out  DATA_W  registered ALU result / load data
RD_o  out  3  registered RD
Dst_reg_o  out  2  registered Dst_reg
Reg_write_o, JAL_o, Mem_reg_o, Excp_o  out  1 each  registered control
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (async, rst=0): state IDLE, wait counter 0, every registered output 0, mem_req=0, stall_o=0, timeout_err=0.
- needs_mem = in_valid & Mem_en & (Mem_read|Mem_write) & ~Excp & ~flush.
- FSM IDLE:
  - needs_mem: mem_req=1 that cycle. mem_we=Mem_write, mem_addr=data_out, mem_wdata=data_two (combinational from inputs). stall_o=1. Capture instruction fields internally. Next state WAIT. MEM/WB loads a bubble (valid_o=0, Reg_write_o=0).
  - Otherwise: stall_o=0. MEM/WB loads the inputs next edge. valid_o=in_valid&~flush, rdata_o=0. Reg_write_o=Reg_write&valid&~Excp. Excp_o=Excp&valid.
- FSM WAIT:
  - mem_req=0. stall_o = ~mem_done.
  - Counter increments each cycle.
  - On mem_done: MEM/WB loads captured fields. rdata_o = mem_rdata if captured op was a read, else 0. valid_o=1 unless flushed flag set. Return to IDLE, clear counter.
  - Counter reaching TIMEOUT-1 without done: return to IDLE. MEM/WB loads valid_o=1, Excp_o=1, Reg_write_o=0. Set timeout_err. Stall releases that cycle. A later stray mem_done in IDLE is ignored.
- Mem_read & Mem_write both 1 with Mem_en: no access. Pass through as exception (Excp_o=1, Reg_write_o=0), zero latency.
- Excp=1 on input: no access. Excp_o=1, Reg_write_o=0.
- flush in IDLE: bubble loaded, no access.
- flush in WAIT: access runs to completion (not cancellable). A flushed flag is set, and the result loads with valid_o=0, Reg_write_o=0.
- Latency: non-memory ops 1 cycle. Memory ops 1 + cycles until mem_done.
- mem_done in the same cycle as mem_req is not legal. Earliest legal done is the cycle after the request.
- Reset mid-WAIT: abandon the access, all outputs to reset values. The bench must not issue mem_done after reset.

Optional Feature:
ALIGN_CHK_EN
- Defined: a memory op with data_out[0]=1 issues no mem_req. The stage passes through in 1 cycle with Excp_o=1 and Reg_write_o=0. timeout_err is unaffected.
- Undefined: no alignment check; the address goes to memory unmodified.

Test Plan:
1. ALU op: in_valid=1, Reg_write=1, data_out=16'h1234, RD=3 -> next edge valid_o=1, alu_o=16'h1234, RD_o=3, Reg_write_o=1, stall_o never asserted.
2. Load: Mem_en=1, Mem_read=1, data_out=16'h0040; mem_done 3 cycles after req with rdata=16'hBEEF -> mem_req single pulse, addr 16'h0040, mem_we=0. stall_o high 3 cycles. Then valid_o=1, rdata_o=16'hBEEF.
3. Store: Mem_write=1, data_out=16'h0010, data_two=16'h00A5 -> mem_we=1, wdata 16'h00A5. rdata_o=0 after done.
4. Flush during WAIT of a load -> completes on mem_done, valid_o=0, Reg_write_o=0, stall released.
5. TIMEOUT=4, mem_done never arrives -> after 4 WAIT cycles: Excp_o=1, timeout_err=1, stall_o=0. Stray mem_done later causes no change.
6. rst=0 asserted mid-WAIT between edges -> outputs zero immediately. With ALIGN_CHK_EN, load at 16'h0041 -> no mem_req, Excp_o=1 after 1 cycle.
